serial_add_sequencer: RTL and testbench
=======================================

// Module: serial_add_sequencer
// PURPOSE
//  Bit-serial sequencer wrapped around the single-bit full adder cell (a, b, cin -> sum, cout).
//  It accepts two WIDTH-bit operands plus a carry-in, and feeds one bit pair per cycle, LSB first, to the cell.
//  Each cycle it registers the cell's cout back into cin and shifts the cell's sum into a result register.
//  Upstream it sits behind operand registers; downstream it feeds result consumers. This gives WIDTH-bit addition from one full adder cell.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range 1..32
// PORTS
//  clk      in   1      single clock; all state updates on rising edge
//  rst      in   1      synchronous, active-high reset
//  start    in   1      request; accepted only in IDLE
//  op_a     in   WIDTH  operand A, sampled on accepting edge
//  op_b     in   WIDTH  operand B, sampled on accepting edge
//  cin0     in   1      initial carry-in, sampled on accepting edge
//  fa_a     out  1      to full adder a input
//  fa_b     out  1      to full adder b input
//  fa_cin   out  1      to full adder carry input
//  fa_sum   in   1      from full adder sum output (combinational, same cycle)
//  fa_cout  in   1      from full adder carry output (combinational, same cycle)
//  busy     out  1      high while in SHIFT
//  done     out  1      one-cycle pulse; result valid
//  sum      out  WIDTH  registered result; held until next completion
//  cout     out  1      registered final carry; held with sum
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, sum=0, cout=0, fa_a=fa_b=fa_cin=0; all internal regs=0.
//  rst wins over all other inputs. Asserting rst mid-operation aborts the operation.
//   The next state is IDLE, and no done pulse is produced.
//  States:
//   IDLE: fa_* driven 0.
//    If start=1: a_sr<=op_a, b_sr<=op_b, c_reg<=cin0, s_sr<=0, cnt<=0, go to SHIFT.
//   SHIFT: busy=1. fa_a=a_sr[0], fa_b=b_sr[0], fa_cin=c_reg (all driven from registers).
//    Each edge: s_sr<={fa_sum,s_sr[WIDTH-1:1]}; c_reg<=fa_cout; a_sr,b_sr shift right by 1; cnt<=cnt+1.
//    On the edge where cnt==WIDTH-1: sum<={fa_sum,s_sr[WIDTH-1:1]}, cout<=fa_cout, go to DONE.
//   DONE: done=1 for exactly one cycle; busy=0; fa_* driven 0; next state IDLE.
//  Latency: start accepted at edge k. SHIFT occupies cycles k+1..k+WIDTH. done is high in cycle k+WIDTH+1.
//   The earliest next accept is edge k+WIDTH+2.
//  start is ignored in SHIFT and DONE and is not queued.
//  op_a/op_b/cin0 may change freely after the accepting edge.
//  Result arithmetic: {cout,sum} = op_a + op_b + cin0, computed in WIDTH+1 bits with no truncation.
//  sum and cout change only on the edge that enters DONE, or on rst. Otherwise they hold, including across IDLE.
//  cnt width = clog2(WIDTH), minimum 1 bit. For WIDTH=1, SHIFT lasts exactly one cycle.
// TESTING
//  Bench drives the fa_* loop with a behavioural full adder: sum=a^b^c, cout=maj(a,b,c).
//  1. WIDTH=8, op_a=0x5A, op_b=0x33, cin0=0, start at edge k.
//     -> busy high cycles k+1..k+8; done in cycle k+9 only; sum=0x8D, cout=0.
//  2. WIDTH=8, 0xFF+0x01, cin0=0 -> sum=0x00, cout=1. Also check the fa_cin sequence is 0,1,1,1,1,1,1,1.
//  3. WIDTH=8, 0xFF+0xFF, cin0=1 -> sum=0xFF, cout=1. Then a new start with 0x00+0x00, cin0=0 -> sum=0x00, cout=0.
//  4. Second start=1 with op_a=0x11 in SHIFT cycle 3 of a 0x5A+0x33 op.
//     -> ignored; a single done pulse; sum=0x8D.
//  5. rst=1 in SHIFT cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0, fa_*=0.
//     A following start with 0x01+0x02 completes: sum=0x03.
//  6. WIDTH=1, op_a=1, op_b=1, cin0=1 at edge k -> done in cycle k+2; sum=1, cout=1.

Source files
------------

// File: rtl/serial_add_sequencer_if.sv
// serial_add_sequencer_if: request/result bundle between operand source (master) and the sequencer (slave).
//   start, op_a, op_b, cin0 : request from master
//   busy, done, sum, cout   : status/result from slave
interface serial_add_sequencer_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  modport master(output start, op_a, op_b, cin0, input busy, done, sum, cout);
  modport slave(input start, op_a, op_b, cin0, output busy, done, sum, cout);
endinterface

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: WIDTH-bit adder built by sequencing one external full adder cell, LSB first.
//   clk, rst            : clock, synchronous active-high reset
//   bus (slave)         : start/op_a/op_b/cin0 request, busy/done/sum/cout result
//   fa_a, fa_b, fa_cin  : operand bits and carry driven to the full adder cell
//   fa_sum, fa_cout     : combinational outputs of the full adder cell
module serial_add_sequencer #(parameter int WIDTH = 8) (
  input  logic clk,
  input  logic rst,
  serial_add_sequencer_if.slave bus,
  output logic fa_a,
  output logic fa_b,
  output logic fa_cin,
  input  logic fa_sum,
  input  logic fa_cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_nx, sum_r;
  logic c_reg, cout_r, last;
  logic [CW-1:0] cnt;
  // Whole-vector shift keeps WIDTH=1 legal: the new sum bit enters at the MSB.
  assign s_nx = WIDTH'({fa_sum, s_sr} >> 1);
  assign last = cnt == CW'(WIDTH - 1);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  always_comb begin
    state_nx = state == IDLE  ? (bus.start ? SHIFT : IDLE) :
               state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    bus.busy = state == SHIFT;
    bus.done = state == DONE;
    fa_a     = bus.busy & a_sr[0];
    fa_b     = bus.busy & b_sr[0];
    fa_cin   = bus.busy & c_reg;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      s_sr   <= '0;
      c_reg  <= 1'b0;
      cnt    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.start) begin
        a_sr  <= bus.op_a;
        b_sr  <= bus.op_b;
        c_reg <= bus.cin0;
        s_sr  <= '0;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        s_sr  <= s_nx;
        c_reg <= fa_cout;
        cnt   <= cnt + 1'b1;
        if (last) begin
          sum_r  <= s_nx;
          cout_r <= fa_cout;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer: directed vectors with a result scoreboard for 8-bit and 1-bit sequencers.
module tb_serial_add_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  serial_add_sequencer_if #(.WIDTH(8)) b8();
  serial_add_sequencer_if #(.WIDTH(1)) b1();
  logic a8, bb8, c8, s8, co8, a1, bb1, c1, s1, co1;
  assign s8  = a8 ^ bb8 ^ c8;
  assign co8 = (a8 & bb8) | (a8 & c8) | (bb8 & c8);
  assign s1  = a1 ^ bb1 ^ c1;
  assign co1 = (a1 & bb1) | (a1 & c1) | (bb1 & c1);
  serial_add_sequencer #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8),
    .fa_a(a8), .fa_b(bb8), .fa_cin(c8), .fa_sum(s8), .fa_cout(co8));
  serial_add_sequencer #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(b1),
    .fa_a(a1), .fa_b(bb1), .fa_cin(c1), .fa_sum(s1), .fa_cout(co1));
  int vectors = 0;
  int miscompares = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];
  logic [8:0] e8;
  logic [1:0] e1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [8:0] res, input bit push);
    b8.start = 1'b1;
    b8.op_a = a;
    b8.op_b = b;
    b8.cin0 = c;
    if (push) q8.push_back(res);
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    b8.op_a = 8'($urandom);
    b8.op_b = 8'($urandom);
    b8.cin0 = 1'($urandom);
  endtask
  task automatic watch(input logic [7:0] cinseq, input logic [8:0] res, input int inj);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("busy_shift", b8.busy, 1);
      chk("done_early", b8.done, 0);
      chk("fa_cin_seq", c8, cinseq[i]);
      if (i + 1 == inj) begin
        b8.start = 1'b1;
        b8.op_a = 8'h11;
      end
      if (i == inj) b8.start = 1'b0;
    end
    @(negedge clk);
    chk("done_pulse", b8.done, 1);
    chk("busy_in_done", b8.busy, 0);
    chk("fa_idle_done", {a8, bb8, c8}, 0);
    @(negedge clk);
    chk("done_single", b8.done, 0);
    chk("busy_after", b8.busy, 0);
    chk("result_hold", {b8.cout, b8.sum}, res);
  endtask
  initial begin
    b8.start = 1'b0; b8.op_a = '0; b8.op_b = '0; b8.cin0 = 1'b0;
    b1.start = 1'b0; b1.op_a = '0; b1.op_b = '0; b1.cin0 = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (b8.done) begin
          chk("done8_queued", q8.size() != 0, 1);
          if (q8.size() != 0) begin
            e8 = q8.pop_front();
            chk("result8", {b8.cout, b8.sum}, e8);
          end
        end
        if (b1.done) begin
          chk("done1_queued", q1.size() != 0, 1);
          if (q1.size() != 0) begin
            e1 = q1.pop_front();
            chk("result1", {b1.cout, b1.sum}, e1);
          end
        end
      end
    join_none
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_state", {b8.busy, b8.done, b8.cout, b8.sum, a8, bb8, c8}, 0);
    chk("rst_state1", {b1.busy, b1.done, b1.cout, b1.sum}, 0);
    go8(8'h5A, 8'h33, 1'b0, 9'h08D, 1);
    watch(8'hE4, 9'h08D, 0);
    go8(8'hFF, 8'h01, 1'b0, 9'h100, 1);
    watch(8'hFE, 9'h100, 0);
    go8(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1);
    watch(8'hFF, 9'h1FF, 0);
    go8(8'h00, 8'h00, 1'b0, 9'h000, 1);
    watch(8'h00, 9'h000, 0);
    go8(8'h5A, 8'h33, 1'b0, 9'h08D, 1);
    watch(8'hE4, 9'h08D, 3);
    repeat (3) @(negedge clk);
    chk("start_not_queued", b8.busy, 0);
    go8(8'h5A, 8'h33, 1'b0, 9'h08D, 0);
    repeat (4) @(negedge clk);
    chk("busy_before_rst", b8.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy_done", {b8.busy, b8.done}, 0);
    chk("abort_result", {b8.cout, b8.sum}, 0);
    chk("abort_fa", {a8, bb8, c8}, 0);
    go8(8'h01, 8'h02, 1'b0, 9'h003, 1);
    watch(8'h00, 9'h003, 0);
    b1.start = 1'b1; b1.op_a = 1'b1; b1.op_b = 1'b1; b1.cin0 = 1'b1;
    q1.push_back(2'b11);
    @(posedge clk);
    #1 b1.start = 1'b0; b1.op_a = 1'b0; b1.op_b = 1'b0; b1.cin0 = 1'b0;
    @(negedge clk);
    chk("w1_busy", {b1.busy, b1.done}, 2'b10);
    chk("w1_fa", {a1, bb1, c1}, 3'b111);
    @(negedge clk);
    chk("w1_done", {b1.busy, b1.done}, 2'b01);
    @(negedge clk);
    chk("w1_done_single", b1.done, 0);
    chk("w1_hold", {b1.cout, b1.sum}, 2'b11);
    repeat (3) @(negedge clk);
    chk("sb8_drained", q8.size(), 0);
    chk("sb1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
